fc_mac_sequencer: RTL and testbench
===================================

Name: fc_mac_sequencer

Overview:
Controller for the 20-lane FC multiplier_accumulator datapath. It sequences one fully-connected layer: it issues weight and input SRAM read addresses chunk by chunk, drives the MAC's accumulate_reset so each output neuron starts a fresh sum, and flags when the MAC's data_out holds a finished neuron sum. It sits between the top-level layer FSM (start/done) and the weight SRAM, input-feature SRAM and MAC.

Parameters:
MAC_NUM, 20, products per MAC cycle (lanes); IN_LEN must be a multiple of it
IN_LEN, 800, input vector length; CHUNKS = IN_LEN/MAC_NUM (localparam, >=1)
OUT_NUM, 500, output neurons per layer (>=1)
WADDR_W, 15, weight SRAM address width (must hold OUT_NUM*CHUNKS-1)
IADDR_W, 6, input SRAM address width (must hold CHUNKS-1)
OIDX_W, 9, output index width (must hold OUT_NUM-1)

Ports:
clk  in  1  clock, all logic on rising edge
srst  in  1  synchronous reset, active-high
start  in  1  pulse; begin a layer pass (sampled only in IDLE)
busy  out  1  high from first issue cycle through final out_valid cycle
done  out  1  one-cycle pulse, coincident with last out_valid
sram_ren  out  1  read enable for weight and input SRAMs
sram_raddr_weight  out  WADDR_W  weight row address = out_idx*CHUNKS + chunk
sram_raddr_input  out  IADDR_W  input row address = chunk
accumulate_reset  out  1  to MAC; high in the cycle chunk 0 of a neuron reaches the MAC
out_valid  out  1  MAC data_out is a complete neuron sum this cycle
out_index  out  OIDX_W  neuron index of the sum flagged by out_valid

Behaviour:
- Reset: while srst=1, state=IDLE and all outputs are 0, including addresses and out_index. srst overrides start in the same cycle. Reset mid-pass aborts immediately; no done is produced.
- Pipeline contract: addresses issued in cycle c give SRAM data at c+1. The MAC registers the weight, so the product is applied at c+2. The accumulator register holds it at c+3. The input-data path to src_window carries one external register so it aligns at c+2; this block does not touch data.
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN when start=1 at a clock edge. The first issue happens in the following cycle.
- RUN: one issue per cycle with sram_ren=1, so there are no bubbles. A chunk counter runs 0..CHUNKS-1 and wraps to 0 while out_idx increments. Neurons are issued back-to-back. After the issue with out_idx=OUT_NUM-1 and chunk=CHUNKS-1, go to DRAIN.
- DRAIN: exactly 3 cycles with sram_ren=0 and addresses held at their last value, then go to IDLE.
- accumulate_reset = issue-of-chunk-0 delayed 2 cycles. It is a shift register, so it stays correct across the RUN->DRAIN boundary.
- out_valid = issue-of-chunk-(CHUNKS-1) delayed 3 cycles. out_index is the neuron index of that issue, delayed 3 cycles. It holds its value when out_valid=0.
- done = out_valid AND out_index==OUT_NUM-1, a 1-cycle pulse. busy falls in the cycle after done.
- start while busy (including the done cycle) is ignored. A start in the first IDLE cycle after done is accepted.
- CHUNKS=1: accumulate_reset and out_valid are high on every steady-state cycle.
- Counters never exceed their terminal values. No wrap past OUT_NUM.
- Total pass length: OUT_NUM*CHUNKS + 3 cycles of busy.

Test Plan:
- Params MAC_NUM=20, IN_LEN=60, OUT_NUM=3 (CHUNKS=3); start at edge 0 -> sram_ren in cycles 1-9; weight addr 0..8; input addr 0,1,2 repeating; accumulate_reset in cycles 3,6,9; out_valid in cycles 6,9,12 with out_index 0,1,2; done in cycle 12 only; busy in cycles 1-12.
- Same params, MAC model plus SRAM models with all inputs=1, weight row w filled with (w mod 3)-1 -> data_out at out_valid = 20*(-1+0+1)=0 for every neuron. Second run with all weights=1 gives 60 for each neuron.
- CHUNKS=1 (IN_LEN=20), OUT_NUM=4 -> accumulate_reset in cycles 3-6; out_valid in cycles 4-7 with out_index 0..3; done in cycle 7.
- start re-pulsed in cycles 5 and 12 -> ignored, with an identical waveform. start in cycle 13 -> new pass, first issue in cycle 14 at weight addr 0.
- srst asserted in cycle 5 mid-run -> next cycle all outputs are 0 and state is IDLE; no out_valid or done follows. A later start runs a full correct pass.
- srst and start both high in the same cycle -> stays IDLE, busy=0.

Source files
------------

// File: rtl/fc_mac_sequencer_if.sv
// Control/address bundle between the FC MAC sequencer, the layer FSM, the SRAMs and the MAC.
// master is the sequencer side; slave is the environment side.
interface fc_mac_sequencer_if #(
  parameter int unsigned WADDR_W = 15,
  parameter int unsigned IADDR_W = 6,
  parameter int unsigned OIDX_W  = 9
);
  logic               start;
  logic               busy;
  logic               done;
  logic               sram_ren;
  logic [WADDR_W-1:0] sram_raddr_weight;
  logic [IADDR_W-1:0] sram_raddr_input;
  logic               accumulate_reset;
  logic               out_valid;
  logic [OIDX_W-1:0]  out_index;

  modport master (
    input  start,
    output busy, done, sram_ren, sram_raddr_weight, sram_raddr_input,
           accumulate_reset, out_valid, out_index
  );

  modport slave (
    output start,
    input  busy, done, sram_ren, sram_raddr_weight, sram_raddr_input,
           accumulate_reset, out_valid, out_index
  );
endinterface

// File: rtl/fc_mac_sequencer.sv
// Sequences one fully-connected layer: streams weight/input row reads chunk by chunk and
// aligns accumulate_reset / out_valid / out_index with the MAC's 2- and 3-cycle latencies.
module fc_mac_sequencer #(
  parameter int unsigned MAC_NUM = 20,
  parameter int unsigned IN_LEN  = 800,
  parameter int unsigned OUT_NUM = 500,
  parameter int unsigned WADDR_W = 15,
  parameter int unsigned IADDR_W = 6,
  parameter int unsigned OIDX_W  = 9
) (
  input  logic                clk,
  input  logic                srst,
  fc_mac_sequencer_if.master  bus
);

  localparam int unsigned CHUNKS    = IN_LEN / MAC_NUM;
  localparam int unsigned DRAIN_CYC = 3;

  localparam logic [IADDR_W-1:0] CHUNK_LAST = IADDR_W'(CHUNKS - 1);
  localparam logic [OIDX_W-1:0]  IDX_LAST   = OIDX_W'(OUT_NUM - 1);
  localparam logic [1:0]         DRAIN_LAST = 2'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [IADDR_W-1:0] chunk, chunk_n;
  logic [OIDX_W-1:0]  idx, idx_n;
  logic [WADDR_W-1:0] waddr, waddr_n;
  logic               ren, ren_n;
  logic               busy_q, busy_n;
  logic [1:0]         drain_cnt, drain_cnt_n;

  logic               last_chunk;
  logic               last_issue;
  logic               issue_first;
  logic               issue_last;

  // Alignment pipeline towards the MAC
  logic               ar_d1;
  logic               acc_rst_q;
  logic               ov_d1, ov_d2, out_valid_q;
  logic [OIDX_W-1:0]  idx_d1, idx_d2, out_index_q;
  logic               done_q;

  assign last_chunk  = (chunk == CHUNK_LAST);
  assign last_issue  = last_chunk && (idx == IDX_LAST);
  assign issue_first = ren && (chunk == '0);
  assign issue_last  = ren && last_chunk;

  // State and issue-counter registers
  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= IDLE;
      chunk     <= '0;
      idx       <= '0;
      waddr     <= '0;
      ren       <= 1'b0;
      busy_q    <= 1'b0;
      drain_cnt <= '0;
    end else begin
      state     <= state_n;
      chunk     <= chunk_n;
      idx       <= idx_n;
      waddr     <= waddr_n;
      ren       <= ren_n;
      busy_q    <= busy_n;
      drain_cnt <= drain_cnt_n;
    end
  end

  // Next state; the registered counters always hold the address being issued this cycle
  always_comb begin
    state_n     = state;
    chunk_n     = chunk;
    idx_n       = idx;
    waddr_n     = waddr;
    ren_n       = 1'b0;
    busy_n      = busy_q;
    drain_cnt_n = drain_cnt;

    unique case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (bus.start) begin
          state_n = RUN;
          chunk_n = '0;
          idx_n   = '0;
          waddr_n = '0;
          ren_n   = 1'b1;
          busy_n  = 1'b1;
        end
      end

      RUN: begin
        busy_n = 1'b1;
        if (last_issue) begin
          state_n     = DRAIN;
          drain_cnt_n = '0;
        end else begin
          ren_n   = 1'b1;
          waddr_n = waddr + WADDR_W'(1);
          if (last_chunk) begin
            chunk_n = '0;
            idx_n   = idx + OIDX_W'(1);
          end else begin
            chunk_n = chunk + IADDR_W'(1);
          end
        end
      end

      DRAIN: begin
        busy_n = 1'b1;
        if (drain_cnt == DRAIN_LAST) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else begin
          drain_cnt_n = drain_cnt + 2'd1;
        end
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // accumulate_reset lands 2 cycles after the chunk-0 issue, out_valid 3 after the last chunk
  always_ff @(posedge clk) begin
    if (srst) begin
      ar_d1       <= 1'b0;
      acc_rst_q   <= 1'b0;
      ov_d1       <= 1'b0;
      ov_d2       <= 1'b0;
      out_valid_q <= 1'b0;
      idx_d1      <= '0;
      idx_d2      <= '0;
      out_index_q <= '0;
      done_q      <= 1'b0;
    end else begin
      ar_d1       <= issue_first;
      acc_rst_q   <= ar_d1;
      ov_d1       <= issue_last;
      ov_d2       <= ov_d1;
      out_valid_q <= ov_d2;
      idx_d1      <= idx;
      idx_d2      <= idx_d1;
      if (ov_d2) begin
        out_index_q <= idx_d2;
      end
      done_q      <= ov_d2 && (idx_d2 == IDX_LAST);
    end
  end

  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.sram_ren          = ren;
  assign bus.sram_raddr_weight = waddr;
  assign bus.sram_raddr_input  = chunk;
  assign bus.accumulate_reset  = acc_rst_q;
  assign bus.out_valid         = out_valid_q;
  assign bus.out_index         = out_index_q;

endmodule

// File: tb/tb_fc_mac_sequencer.sv
// Directed bench for fc_mac_sequencer: a CHUNKS=3/OUT_NUM=3 instance driving SRAM+MAC models,
// and a CHUNKS=1/OUT_NUM=4 instance; cycle k is the k-th cycle after the start-sampling edge.
module tb_fc_mac_sequencer;

  logic clk;
  logic srst;
  int   checks;
  int   errors;

  fc_mac_sequencer_if #(.WADDR_W(15), .IADDR_W(6), .OIDX_W(9)) bus_a ();
  fc_mac_sequencer_if #(.WADDR_W(15), .IADDR_W(6), .OIDX_W(9)) bus_b ();

  fc_mac_sequencer #(
    .MAC_NUM(20), .IN_LEN(60), .OUT_NUM(3), .WADDR_W(15), .IADDR_W(6), .OIDX_W(9)
  ) dut_a (
    .clk  (clk),
    .srst (srst),
    .bus  (bus_a)
  );

  fc_mac_sequencer #(
    .MAC_NUM(20), .IN_LEN(20), .OUT_NUM(4), .WADDR_W(15), .IADDR_W(6), .OIDX_W(9)
  ) dut_b (
    .clk  (clk),
    .srst (srst),
    .bus  (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM + MAC model for instance A: SRAM data at c+1, weight/input regs at c+2, accumulator at c+3
  logic [19:0][7:0] wmem [0:8];
  logic [19:0][7:0] imem [0:2];
  logic [19:0][7:0] w_q, i_q, w_mac, i_ext;
  logic [3:0]       wa;
  logic [1:0]       ia;
  int               acc;

  assign wa = bus_a.sram_raddr_weight[3:0];
  assign ia = bus_a.sram_raddr_input[1:0];

  function automatic int dot(input logic [19:0][7:0] w, input logic [19:0][7:0] x);
    int s;
    s = 0;
    for (int l = 0; l < 20; l++) s += int'($signed(w[l])) * int'($signed(x[l]));
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (bus_a.sram_ren) begin
      w_q <= wmem[wa];
      i_q <= imem[ia];
    end
    w_mac <= w_q;
    i_ext <= i_q;
    if (bus_a.accumulate_reset) acc <= dot(w_mac, i_ext);
    else                        acc <= acc + dot(w_mac, i_ext);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_a(input string tag);
    chk({tag, "_ren"},  int'(bus_a.sram_ren), 0);
    chk({tag, "_wa"},   int'(bus_a.sram_raddr_weight), 0);
    chk({tag, "_ia"},   int'(bus_a.sram_raddr_input), 0);
    chk({tag, "_ar"},   int'(bus_a.accumulate_reset), 0);
    chk({tag, "_ov"},   int'(bus_a.out_valid), 0);
    chk({tag, "_oi"},   int'(bus_a.out_index), 0);
    chk({tag, "_done"}, int'(bus_a.done), 0);
    chk({tag, "_busy"}, int'(bus_a.busy), 0);
  endtask

  // Expected waveform for instance A (CHUNKS=3, OUT_NUM=3), hand-derived
  task automatic check_a(input int k, input int prev_idx, input int exp_data);
    int e_ren, e_wa, e_ia, e_ar, e_ov, e_oi, e_done, e_busy;
    e_ren  = (k >= 1 && k <= 9) ? 1 : 0;
    e_wa   = (k <= 9) ? k - 1 : 8;
    e_ia   = (k <= 9) ? (k - 1) % 3 : 2;
    e_ar   = (k == 3 || k == 6 || k == 9) ? 1 : 0;
    e_ov   = (k == 6 || k == 9 || k == 12) ? 1 : 0;
    e_oi   = (k < 6) ? prev_idx : (k < 9) ? 0 : (k < 12) ? 1 : 2;
    e_done = (k == 12) ? 1 : 0;
    e_busy = (k >= 1 && k <= 12) ? 1 : 0;
    chk($sformatf("a_ren@%0d", k),  int'(bus_a.sram_ren), e_ren);
    chk($sformatf("a_wa@%0d", k),   int'(bus_a.sram_raddr_weight), e_wa);
    chk($sformatf("a_ia@%0d", k),   int'(bus_a.sram_raddr_input), e_ia);
    chk($sformatf("a_ar@%0d", k),   int'(bus_a.accumulate_reset), e_ar);
    chk($sformatf("a_ov@%0d", k),   int'(bus_a.out_valid), e_ov);
    chk($sformatf("a_oi@%0d", k),   int'(bus_a.out_index), e_oi);
    chk($sformatf("a_done@%0d", k), int'(bus_a.done), e_done);
    chk($sformatf("a_busy@%0d", k), int'(bus_a.busy), e_busy);
    if (e_ov == 1) chk($sformatf("a_data@%0d", k), acc, exp_data);
  endtask

  task automatic start_pass_a();
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
  endtask

  // Checks cycles 1..last_k; optionally re-pulses start in cycles 5 and 12, or in last_k
  task automatic watch_a(input int last_k, input bit repulse, input bit restart,
                         input int prev_idx, input int exp_data);
    for (int k = 1; k <= last_k; k++) begin
      if (k > 1) step();
      check_a(k, prev_idx, exp_data);
      bus_a.start = (repulse && (k == 5 || k == 12)) || (restart && k == last_k);
    end
  endtask

  // Expected waveform for instance B (CHUNKS=1, OUT_NUM=4)
  task automatic watch_b(input int last_k);
    int e_oi;
    for (int k = 1; k <= last_k; k++) begin
      if (k > 1) step();
      e_oi = (k < 4) ? 0 : (k <= 7) ? k - 4 : 3;
      chk($sformatf("b_ren@%0d", k),  int'(bus_b.sram_ren), (k <= 4) ? 1 : 0);
      chk($sformatf("b_wa@%0d", k),   int'(bus_b.sram_raddr_weight), (k <= 4) ? k - 1 : 3);
      chk($sformatf("b_ia@%0d", k),   int'(bus_b.sram_raddr_input), 0);
      chk($sformatf("b_ar@%0d", k),   int'(bus_b.accumulate_reset), (k >= 3 && k <= 6) ? 1 : 0);
      chk($sformatf("b_ov@%0d", k),   int'(bus_b.out_valid), (k >= 4 && k <= 7) ? 1 : 0);
      chk($sformatf("b_oi@%0d", k),   int'(bus_b.out_index), e_oi);
      chk($sformatf("b_done@%0d", k), int'(bus_b.done), (k == 7) ? 1 : 0);
      chk($sformatf("b_busy@%0d", k), int'(bus_b.busy), (k <= 7) ? 1 : 0);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    srst        = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    for (int r = 0; r < 3; r++) imem[r] = {20{8'sd1}};
    for (int w = 0; w < 9; w++) wmem[w] = {20{8'((w % 3) - 1)}};

    // Reset state
    repeat (3) step();
    check_zero_a("rst");
    chk("rst_b_busy", int'(bus_b.busy), 0);
    chk("rst_b_ren",  int'(bus_b.sram_ren), 0);
    srst = 1'b0;
    step();
    chk("idle_a_busy", int'(bus_a.busy), 0);

    // Pass with start re-pulsed while busy, then restart in the first idle cycle
    start_pass_a();
    watch_a(13, 1'b1, 1'b1, 0, 0);
    for (int w = 0; w < 9; w++) wmem[w] = {20{8'sd1}};
    start_pass_a();
    watch_a(15, 1'b0, 1'b0, 2, 60);

    // Reset in cycle 5 aborts the pass
    start_pass_a();
    watch_a(5, 1'b0, 1'b0, 2, 60);
    srst = 1'b1;
    step();
    srst = 1'b0;
    check_zero_a("abort");
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("abort_ov@%0d", k),   int'(bus_a.out_valid), 0);
      chk($sformatf("abort_done@%0d", k), int'(bus_a.done), 0);
      chk($sformatf("abort_busy@%0d", k), int'(bus_a.busy), 0);
    end
    start_pass_a();
    watch_a(15, 1'b0, 1'b0, 0, 60);

    // Reset wins over start in the same cycle
    srst        = 1'b1;
    bus_a.start = 1'b1;
    step();
    srst        = 1'b0;
    bus_a.start = 1'b0;
    chk("rst_start_busy", int'(bus_a.busy), 0);
    chk("rst_start_ren",  int'(bus_a.sram_ren), 0);
    step();
    chk("rst_start_busy2", int'(bus_a.busy), 0);
    chk("rst_start_ren2",  int'(bus_a.sram_ren), 0);

    // Single-chunk configuration
    bus_b.start = 1'b1;
    step();
    bus_b.start = 1'b0;
    watch_b(9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
